eth_tx_framer: RTL and testbench

//  Builds complete Ethernet II frames for the RGMII transmit stage in the clk125 domain.
//  - Input: a byte stream of payload (destination MAC through end of data) on a valid/ready/last handshake.
//  - Output: a GMII-style byte stream with preamble, SFD, zero-padding to minimum size, CRC32 FCS and

---
 rtl/eth_tx_framer.sv | 161 ++++++++++++++++
 tb/tb_eth_tx_framer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_framer.sv
// Ethernet II transmit framer: wraps a payload byte stream with preamble/SFD, zero pad,
// CRC32 FCS and inter-frame gap, producing registered GMII-style byte outputs.
module eth_tx_framer #(
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_PAYLOAD  = 60,
    parameter int MAX_PAYLOAD  = 1514,
    parameter int IFG_BYTES    = 12
) (
    input  logic       clk125,
    input  logic       rst_n,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [7:0] gmii_txd,
    output logic       gmii_txen,
    output logic       gmii_txer,
    output logic       busy
);
    localparam logic [10:0] PRE_LAST = 11'(PREAMBLE_LEN - 1);
    localparam logic [10:0] MIN_LEN  = 11'(MIN_PAYLOAD);
    localparam logic [10:0] MAX_LEN  = 11'(MAX_PAYLOAD);
    localparam logic [10:0] IFG_LAST = 11'(IFG_BYTES - 1);
    localparam logic [31:0] CRC_POLY = 32'hEDB88320;

    typedef enum logic [3:0] {
        S_IDLE, S_PRE, S_SFD, S_DATA, S_PAD, S_FCS, S_ERR, S_DRAIN, S_IFG
    } state_e;

    state_e      state_q, state_d;
    logic [10:0] cnt_q, cnt_d;
    logic [31:0] crc_q, crc_d;
    logic [7:0]  txd_q, txd_d;
    logic        txen_q, txen_d;
    logic        txer_q, txer_d;
    logic [10:0] cnt_inc;
    logic [31:0] fcs_shift;

    function automatic logic [31:0] crc_next(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        return c;
    endfunction

    assign cnt_inc   = cnt_q + 11'd1;
    // FCS goes out as ~crc, least-significant byte first; cnt_q indexes the byte
    assign fcs_shift = ~crc_q >> {cnt_q[1:0], 3'b000};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        crc_d   = crc_q;
        txd_d   = 8'h00;
        txen_d  = 1'b0;
        txer_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                // first preamble byte is launched on the same edge that sees s_valid
                if (s_valid) begin
                    state_d = S_PRE;
                    txd_d   = 8'h55;
                    txen_d  = 1'b1;
                    cnt_d   = 11'd1;
                    crc_d   = '1;
                end
            end
            S_PRE: begin
                txd_d  = 8'h55;
                txen_d = 1'b1;
                cnt_d  = cnt_inc;
                if (cnt_q == PRE_LAST) state_d = S_SFD;
            end
            S_SFD: begin
                txd_d   = 8'hD5;
                txen_d  = 1'b1;
                cnt_d   = '0;
                state_d = S_DATA;
            end
            S_DATA: begin
                txen_d = 1'b1;
                if (s_valid) begin
                    txd_d = s_data;
                    crc_d = crc_next(crc_q, s_data);
                    cnt_d = cnt_inc;
                    if (s_last) begin
                        if (cnt_inc < MIN_LEN) begin
                            state_d = S_PAD;
                        end else begin
                            state_d = S_FCS;
                            cnt_d   = '0;
                        end
                    end else if (cnt_inc == MAX_LEN) begin
                        state_d = S_ERR;
                    end
                end else begin
                    txer_d  = 1'b1;
                    state_d = S_DRAIN;
                end
            end
            S_PAD: begin
                txen_d = 1'b1;
                crc_d  = crc_next(crc_q, 8'h00);
                cnt_d  = cnt_inc;
                if (cnt_inc == MIN_LEN) begin
                    state_d = S_FCS;
                    cnt_d   = '0;
                end
            end
            S_FCS: begin
                txd_d  = fcs_shift[7:0];
                txen_d = 1'b1;
                cnt_d  = cnt_inc;
                if (cnt_q[1:0] == 2'd3) begin
                    state_d = S_IFG;
                    cnt_d   = '0;
                end
            end
            S_ERR: begin
                txen_d  = 1'b1;
                txer_d  = 1'b1;
                state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (s_valid && s_last) begin
                    state_d = S_IFG;
                    cnt_d   = '0;
                end
            end
            S_IFG: begin
                cnt_d = cnt_inc;
                if (cnt_q == IFG_LAST) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk125 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            crc_q   <= '1;
            txd_q   <= 8'h00;
            txen_q  <= 1'b0;
            txer_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            crc_q   <= crc_d;
            txd_q   <= txd_d;
            txen_q  <= txen_d;
            txer_q  <= txer_d;
        end
    end

    assign s_ready   = (state_q == S_DATA) || (state_q == S_DRAIN);
    assign busy      = (state_q != S_IDLE);
    assign gmii_txd  = txd_q;
    assign gmii_txen = txen_q;
    assign gmii_txer = txer_q;
endmodule

// File: tb/tb_eth_tx_framer.sv
// Directed bench for eth_tx_framer: a frame-level model builds the expected GMII byte stream
// from each payload and a monitor compares every transmitted byte, frame length and gap.
`timescale 1ns/1ps
module tb_eth_tx_framer;
    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [7:0] d;
        logic       er;
        int         rdy;   // 0/1 expected s_ready, 2 = not checked
    } exp_t;

    logic       clk125 = 1'b0;
    logic       rst_n  = 1'b1;
    logic [7:0] s_data = 8'h00;
    logic       s_valid = 1'b0;
    logic       s_last  = 1'b0;
    logic       s_ready;
    logic [7:0] gmii_txd;
    logic       gmii_txen;
    logic       gmii_txer;
    logic       busy;

    eth_tx_framer dut (
        .clk125(clk125), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready), .gmii_txd(gmii_txd), .gmii_txen(gmii_txen), .gmii_txer(gmii_txer),
        .busy(busy)
    );

    always #4 clk125 = ~clk125;

    int   total = 0, bad = 0;
    exp_t exp_q[$];
    int   len_q[$];
    int   run = 0, gap = 1000;
    bit   exact_gap = 0, idle_rdy_chk = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    // Bit-serial CRC32 over the frame body, returned already inverted (the FCS value)
    function automatic logic [31:0] model_fcs(input bq_t b);
        logic [31:0] c = 32'hFFFF_FFFF;
        logic fb;
        foreach (b[i])
            for (int k = 0; k < 8; k++) begin
                fb = c[0] ^ b[i][k];
                c  = {1'b0, c[31:1]} ^ (fb ? 32'hEDB88320 : 32'h0);
            end
        return ~c;
    endfunction

    function automatic bq_t model_frame(input bq_t p);
        bq_t f, body;
        logic [31:0] fcs;
        body = p;
        while (body.size() < 60) body.push_back(8'h00);
        fcs = model_fcs(body);
        for (int i = 0; i < 7; i++) f.push_back(8'h55);
        f.push_back(8'hD5);
        foreach (body[i]) f.push_back(body[i]);
        for (int k = 0; k < 4; k++) f.push_back(fcs[8*k +: 8]);
        return f;
    endfunction

    function automatic bq_t mk(input int n, input int mul, input int add);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'((i * mul + add) & 255));
        return q;
    endfunction

    // err_at < 0: normal frame; else err_at data bytes then one error byte
    task automatic expect_frame(input bq_t p, input int err_at);
        bq_t f;
        exp_t e;
        if (err_at < 0) begin
            f = model_frame(p);
            foreach (f[i]) begin
                e.d = f[i];
                e.er = 1'b0;
                // framer waits for payload from SFD until the final payload byte is taken
                e.rdy = (i >= 7 && i < 7 + p.size()) ? 1 : 0;
                exp_q.push_back(e);
            end
            len_q.push_back(f.size());
        end else begin
            for (int i = 0; i < 7; i++) begin e.d = 8'h55; e.er = 1'b0; e.rdy = 0; exp_q.push_back(e); end
            e.d = 8'hD5; e.er = 1'b0; e.rdy = 2; exp_q.push_back(e);
            for (int i = 0; i < err_at; i++) begin e.d = p[i]; e.er = 1'b0; e.rdy = 2; exp_q.push_back(e); end
            e.d = 8'h00; e.er = 1'b1; e.rdy = 2; exp_q.push_back(e);
            len_q.push_back(8 + err_at + 1);
        end
    endtask

    task automatic send(input bq_t p, input bit has_last, input int drop_at);
        int idx = 0, cyc = 0;
        bit dropped = 0;
        while (idx < p.size()) begin
            @(negedge clk125);
            cyc++;
            if (cyc > 6000) begin
                chk("send_timeout", idx, p.size());
                s_valid = 1'b0;
                return;
            end
            if (!dropped && drop_at >= 0 && idx == drop_at && s_ready) begin
                dropped = 1;
                s_valid = 1'b0;
                s_last  = 1'b0;
            end else begin
                s_valid = 1'b1;
                s_data  = p[idx];
                s_last  = has_last && (idx == p.size() - 1);
                if (s_ready) idx++;
            end
        end
    endtask

    task automatic release_input();
        @(negedge clk125);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int cyc = 0;
        do begin
            @(negedge clk125);
            #1;
            cyc++;
        end while ((exp_q.size() != 0 || busy) && cyc < 4000);
        chk({name, "_done_timeout"}, cyc >= 4000, 0);
        chk({name, "_leftover"}, exp_q.size(), 0);
    endtask

    always @(negedge clk125) begin : mon
        exp_t e;
        if (rst_n) begin
            if (gmii_txen) begin
                if (run == 0) begin
                    if (exact_gap) chk("ifg_exact", gap, 12);
                    else           chk("ifg_min", gap >= 12, 1);
                end
                run++;
                gap = 0;
                if (exp_q.size() == 0) chk("unexpected_byte", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("txd", gmii_txd, e.d);
                    chk("txer", gmii_txer, e.er);
                    if (e.rdy != 2) chk("s_ready", s_ready, e.rdy);
                    chk("busy_in_frame", busy, 1);
                end
            end else begin
                if (run > 0) begin
                    if (len_q.size() == 0) chk("unexpected_frame", 1, 0);
                    else chk("frame_len", run, len_q.pop_front());
                    run = 0;
                end
                gap++;
                chk("idle_txd", gmii_txd, 8'h00);
                chk("idle_txer", gmii_txer, 1'b0);
                if (idle_rdy_chk) chk("ifg_s_ready", s_ready, 1'b0);
            end
        end
    end

    initial begin
        bq_t f, pl;
        int cyc;

        // model pins: standard CRC32 check value and hand-counted frame layouts
        pl = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        chk("pin_crc_check", model_fcs(pl), 32'hCBF43926);
        f = model_frame(mk(10, 1, 0));
        chk("pin_len10", f.size(), 72);
        chk("pin_sfd", f[7], 8'hD5);
        chk("pin_pre0", f[0], 8'h55);
        chk("pin_data9", f[17], 8'h09);
        chk("pin_pad0", f[18], 8'h00);
        chk("pin_pad_last", f[67], 8'h00);
        chk("pin_len60", model_frame(mk(60, 3, 0)).size(), 72);
        chk("pin_len1514", model_frame(mk(1514, 7, 1)).size(), 1526);

        #1 rst_n = 1'b0;
        #20;
        chk("rst_txen", gmii_txen, 0);
        chk("rst_txer", gmii_txer, 0);
        chk("rst_txd", gmii_txd, 8'h00);
        chk("rst_ready", s_ready, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk125) rst_n = 1'b1;
        repeat (3) @(negedge clk125);

        // 1: short frame padded to minimum
        pl = mk(10, 1, 0);
        expect_frame(pl, -1); send(pl, 1, -1); release_input(); wait_done("t1");

        // 2: exact minimum and maximum payloads
        pl = mk(60, 3, 0);
        expect_frame(pl, -1); send(pl, 1, -1); release_input(); wait_done("t2a");
        pl = mk(1514, 7, 1);
        expect_frame(pl, -1); send(pl, 1, -1); release_input(); wait_done("t2b");

        // 3: back-to-back with s_valid held high, incl. a 1-byte frame starting from IDLE
        idle_rdy_chk = 1;
        pl = mk(1, 1, 8'hA5);
        expect_frame(pl, -1); send(pl, 1, -1);
        exact_gap = 1;
        pl = mk(61, 5, 2);
        expect_frame(pl, -1); send(pl, 1, -1);
        pl = mk(15, 11, 3);
        expect_frame(pl, -1); send(pl, 1, -1);
        // wait for frame 3's preamble before relaxing the exact-gap check
        cyc = 0;
        while (!gmii_txen && cyc < 100) begin @(negedge clk125); #1; cyc++; end
        exact_gap = 0;
        release_input(); wait_done("t3");
        idle_rdy_chk = 0;

        // 4: underrun after 20 bytes, rest drained; then a clean frame
        pl = mk(30, 1, 16);
        expect_frame(pl, 20); send(pl, 1, 20); release_input(); wait_done("t4");
        pl = mk(12, 2, 1);
        expect_frame(pl, -1); send(pl, 1, -1); release_input(); wait_done("t4b");

        // 5: oversize, s_last only on byte 1520
        pl = mk(1520, 13, 4);
        expect_frame(pl, 1514); send(pl, 1, -1); release_input(); wait_done("t5");

        // 6: reset during FCS, then a fresh frame
        pl = mk(10, 1, 0);
        expect_frame(pl, -1); send(pl, 1, -1); release_input();
        cyc = 0;
        do begin @(negedge clk125); #1; cyc++; end while (exp_q.size() != 1 && cyc < 200);
        chk("t6_fcs_timeout", cyc >= 200, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_txen", gmii_txen, 0);
        chk("t6_txer", gmii_txer, 0);
        chk("t6_ready", s_ready, 0);
        chk("t6_busy", busy, 0);
        exp_q.delete(); len_q.delete(); run = 0; gap = 1000;
        repeat (2) @(posedge clk125);
        @(negedge clk125) rst_n = 1'b1;
        pl = mk(20, 9, 7);
        expect_frame(pl, -1); send(pl, 1, -1); release_input(); wait_done("t6");

        repeat (5) @(negedge clk125);
        chk("final_len_q", len_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
